// File: rtl/dilated_activation_cache_pkg.sv
`default_nettype none
// ============================================================================
// Package     : act_cache_pkg
// Description : Shared helpers for the dilated activation cache: history
//               depth, modular subtraction for non-power-of-two circular
//               buffers, and address-width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package act_cache_pkg;

    // Number of stored past samples needed to reach the oldest tap.
    function automatic int hist_depth(input int k, input int dil);
        return (k - 1) * dil;
    endfunction

    // (head - age) mod depth without relying on power-of-two wrap.
    // age never exceeds depth, so a single conditional add is enough.
    function automatic int wrap_sub(input int head, input int age, input int depth);
        return (head >= age) ? (head - age) : (head + depth - age);
    endfunction

    // Address width for a depth-entry array, never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dilated_activation_cache_history_ram.sv
`default_nettype none
// ============================================================================
// Module      : dilated_history_ram
// Description : HIST-entry circular history of activation vectors with one
//               write port and KERNEL_SIZE-1 combinational read ports, one per
//               dilated age. Owns the write head.
// Ports       : clk, rst_n (async active-low), i_clear (flush head),
//               i_we (store i_wdata at head), i_wdata (D*W vector),
//               o_rd (read port j-1 returns sample of age j*DILATION)
// Revision    : 1.0 - initial release
// ============================================================================
module dilated_history_ram
    import act_cache_pkg::*;
#(
    parameter int W           = 16,
    parameter int D           = 2,
    parameter int KERNEL_SIZE = 4,
    parameter int DILATION    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_clear,
    input  logic                             i_we,
    input  logic [D*W-1:0]                   i_wdata,
    output logic [(KERNEL_SIZE-1)*D*W-1:0]   o_rd
);

    localparam int DW   = D * W;
    localparam int HIST = hist_depth(KERNEL_SIZE, DILATION);
    localparam int AW   = addr_width(HIST);
    localparam logic [AW-1:0] c_LAST = AW'(HIST - 1);

    typedef logic [DW-1:0] act_vec_t;

    act_vec_t        r_mem [HIST];
    logic [AW-1:0]   r_wh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wh <= '0;
        end else if (i_clear) begin
            r_wh <= '0;
        end else if (i_we) begin
            r_wh <= (r_wh == c_LAST) ? '0 : r_wh + 1'b1;
        end
    end

    // Contents are deliberately not reset; the top masks unfilled ages.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_wh] <= i_wdata;
        end
    end

    // The age-HIST port addresses slot r_wh itself and sees the value
    // before this edge's write lands (read-before-write).
    for (genvar j = 1; j < KERNEL_SIZE; j++) begin : g_rd
        localparam int AGE = j * DILATION;
        assign o_rd[(j-1)*DW +: DW] = r_mem[AW'(wrap_sub(32'(r_wh), AGE, HIST))];
    end

endmodule
`default_nettype wire

// File: rtl/dilated_activation_cache.sv
`default_nettype none
// ============================================================================
// Module      : dilated_activation_cache
// Description : Presents KERNEL_SIZE dilated taps (oldest first) of a stream
//               of D-channel activation vectors on every accepted input.
//               Taps older than the fill level are zeroed.
// Ports       : clk, rst (async active-low), clear (sync flush, beats
//               in_valid), in_valid/inp (new sample), out_valid (one-cycle
//               pulse), out (packed taps, tap 0 in LSBs = oldest)
// Revision    : 1.0 - initial release
// ============================================================================
module dilated_activation_cache
    import act_cache_pkg::*;
#(
    parameter int W           = 16,
    parameter int D           = 2,
    parameter int DILATION    = 4,
    parameter int KERNEL_SIZE = 4,
    parameter int ZERO_PAD    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [D*W-1:0]                 inp,
    output logic                           out_valid,
    output logic [KERNEL_SIZE*D*W-1:0]     out
);

    localparam int DW   = D * W;
    localparam int HIST = hist_depth(KERNEL_SIZE, DILATION);
    localparam int FW   = $clog2(HIST + 1);
    localparam logic [FW-1:0] c_HIST_F = FW'(HIST);
    localparam bit c_ZP = (ZERO_PAD != 0);

    logic                               w_accept;
    logic [(KERNEL_SIZE-1)*DW-1:0]      w_rd;
    logic [KERNEL_SIZE*DW-1:0]          w_taps;

    logic [FW-1:0]                      r_fill;
    logic [KERNEL_SIZE*DW-1:0]          r_out;
    logic                               r_out_valid;

    assign w_accept = in_valid & ~clear;

    dilated_history_ram #(
        .W           (W),
        .D           (D),
        .KERNEL_SIZE (KERNEL_SIZE),
        .DILATION    (DILATION)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (clear),
        .i_we    (w_accept),
        .i_wdata (inp),
        .o_rd    (w_rd)
    );

    // Tap k has age (KERNEL_SIZE-1-k)*DILATION; age 0 is the live input.
    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_tap
        localparam int J   = KERNEL_SIZE - 1 - k;
        localparam int AGE = J * DILATION;
        if (J == 0) begin : g_newest
            assign w_taps[k*DW +: DW] = inp;
        end else begin : g_past
            assign w_taps[k*DW +: DW] = (r_fill >= FW'(AGE)) ? w_rd[(J-1)*DW +: DW] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
        end else if (clear) begin
            r_fill <= '0;
        end else if (w_accept && (r_fill != c_HIST_F)) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // clear forces w_accept low, so it also kills the valid pulse.
            r_out_valid <= w_accept & (c_ZP | (r_fill == c_HIST_F));
            if (w_accept) begin
                r_out <= w_taps;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_dilated_activation_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dilated_activation_cache
// Description : Self-checking bench. Three instances (kernel 4 / dilation 4
//               zero-padded, same unpadded, kernel 3 / dilation 3) share one
//               stimulus stream; a reference history model predicts each
//               instance's taps, pushed to per-instance scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dilated_activation_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  inp = '0;

    logic         v0, v1, v2;
    logic [127:0] o0, o1;
    logic [95:0]  o2;

    always #5 clk = ~clk;

    dilated_activation_cache #(.W(16), .D(2), .DILATION(4), .KERNEL_SIZE(4), .ZERO_PAD(1)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .inp(inp),
        .out_valid(v0), .out(o0));
    dilated_activation_cache #(.W(16), .D(2), .DILATION(4), .KERNEL_SIZE(4), .ZERO_PAD(0)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .inp(inp),
        .out_valid(v1), .out(o1));
    dilated_activation_cache #(.W(16), .D(2), .DILATION(3), .KERNEL_SIZE(3), .ZERO_PAD(1)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .inp(inp),
        .out_valid(v2), .out(o2));

    int checks = 0;
    int errors = 0;

    // Instance parameters for the model.
    int c_K   [3] = '{4, 4, 3};
    int c_DIL [3] = '{4, 4, 3};
    int c_ZP  [3] = '{1, 0, 1};

    int           hist[$];          // accepted samples since last reset/clear
    logic [127:0] sb0[$], sb1[$], sb2[$];
    bit           expv [3];
    logic [127:0] expo [3];
    bit           chko [3];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int k, input int t0, input int t1, input int t2, input int t3);
        int t[4];
        logic [127:0] r;
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        r = '0;
        for (int i = 0; i < k; i++) begin
            r[i*32 +: 16]      = 16'(t[i]);
            r[i*32 + 16 +: 16] = 16'(t[i]);
        end
        return r;
    endfunction

    function automatic logic [127:0] model_taps(input int k, input int dil, input int cur);
        int t[4];
        for (int i = 0; i < 4; i++) t[i] = 0;
        for (int i = 0; i < k; i++) begin
            int a;
            a = (k - 1 - i) * dil;
            if (a == 0)                t[i] = cur;
            else if (a <= hist.size()) t[i] = hist[hist.size() - a];
            else                       t[i] = 0;
        end
        return pk(k, t[0], t[1], t[2], t[3]);
    endfunction

    task automatic sb_push(input int i, input logic [127:0] x);
        case (i)
            0:       sb0.push_back(x);
            1:       sb1.push_back(x);
            default: sb2.push_back(x);
        endcase
    endtask

    task automatic model_reset();
        hist.delete();
        sb0.delete(); sb1.delete(); sb2.delete();
        for (int i = 0; i < 3; i++) begin
            expv[i] = 1'b0;
            expo[i] = '0;
            chko[i] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic         av;
            logic [127:0] ao;
            logic [127:0] e;
            int           sz;
            case (i)
                0:       begin av = v0; ao = o0;            sz = sb0.size(); end
                1:       begin av = v1; ao = o1;            sz = sb1.size(); end
                default: begin av = v2; ao = {32'd0, o2};   sz = sb2.size(); end
            endcase
            check($sformatf("vld%0d", i), {127'd0, av}, {127'd0, expv[i]});
            if (av) begin
                if (sz == 0) begin
                    check($sformatf("sb_empty%0d", i), {127'd0, av}, 128'd0);
                end else begin
                    case (i)
                        0:       e = sb0.pop_front();
                        1:       e = sb1.pop_front();
                        default: e = sb2.pop_front();
                    endcase
                    check($sformatf("taps%0d", i), ao, e);
                end
            end else if (chko[i]) begin
                check($sformatf("hold%0d", i), ao, expo[i]);
            end
        end
    endtask

    // Drive one cycle from just after a falling edge; check at the next one.
    task automatic drive(input bit v, input int val, input bit clr);
        bit acc;
        in_valid = v;
        clear    = clr;
        inp      = {16'(val), 16'(val)};
        acc      = v && !clr;
        for (int i = 0; i < 3; i++) begin
            if (acc) begin
                int hd;
                hd      = (c_K[i] - 1) * c_DIL[i];
                expv[i] = (c_ZP[i] != 0) || (hist.size() >= hd);
                expo[i] = model_taps(c_K[i], c_DIL[i], val);
                chko[i] = expv[i];
                if (expv[i]) sb_push(i, expo[i]);
            end else begin
                expv[i] = 1'b0;
            end
        end
        if (clr)      hist.delete();
        else if (acc) hist.push_back(val);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_o0", o0, 128'd0);
        check("rst_o2", {32'd0, o2}, 128'd0);
        check("rst_v", {125'd0, v0, v1, v2}, 128'd0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        @(negedge clk);

        // Continuous stream 1..20.
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, n, 1'b0);
            if (n == 1)  check("first0", o0, pk(4, 0, 0, 0, 1));
            if (n == 12) check("zp0_quiet", {127'd0, v1}, 128'd0);
            if (n == 13) check("zp0_first", o1, pk(4, 1, 5, 9, 13));
            if (n == 15) check("k3_15", {32'd0, o2}, pk(3, 9, 12, 15, 0));
        end
        check("last0", o0, pk(4, 8, 12, 16, 20));
        check("last1", o1, pk(4, 8, 12, 16, 20));
        drive(1'b0, 0, 1'b0);

        // Gapped stream 1,0,0,...
        async_reset();
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, n, 1'b0);
            drive(1'b0, n + 100, 1'b0);
            drive(1'b0, n + 200, 1'b0);
        end
        check("gap_last0", o0, pk(4, 8, 12, 16, 20));

        // Clear with in_valid high drops sample 11.
        async_reset();
        for (int n = 1; n <= 10; n++) drive(1'b1, n, 1'b0);
        drive(1'b1, 11, 1'b1);
        drive(1'b1, 12, 1'b0);
        check("clr0", o0, pk(4, 0, 0, 0, 12));
        for (int n = 13; n <= 30; n++) drive(1'b1, n, 1'b0);

        // Async reset mid-stream after sample 7.
        async_reset();
        for (int n = 1; n <= 7; n++) drive(1'b1, n, 1'b0);
        async_reset();
        drive(1'b1, 8, 1'b0);
        check("mid_rst0", o0, pk(4, 0, 0, 0, 8));
        for (int n = 9; n <= 25; n++) drive(1'b1, n, 1'b0);
        drive(1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
